// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared-transmitter arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' and UART's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ack;
    logic [NUM_REQ-1:0]           req_done;
    logic                         timeout;
    logic [IDX_W-1:0]             timeout_idx;
    logic                         busy;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_done_tick;

    modport master (
        output req, req_data, tx_done_tick,
        input  req_ack, req_done, timeout, timeout_idx, busy, tx_start, tx_data
    );

    modport slave (
        input  req, req_data, tx_done_tick,
        output req_ack, req_done, timeout, timeout_idx, busy, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters,
// with a post-frame gap and a watchdog that aborts a frame whose done tick never arrives.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int                 IDX_W    = $clog2(NUM_REQ);
    localparam logic [23:0]        WD_LAST  = (TIMEOUT_CYCLES == 0) ? 24'd0 : 24'(TIMEOUT_CYCLES - 1);
    localparam bit                 WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0]         GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [23:0]          wd_cnt_q;
    logic [3:0]           gap_cnt_q;
    logic [DATA_BITS-1:0] tx_data_q;
    logic [NUM_REQ-1:0]   req_ack_q;
    logic [NUM_REQ-1:0]   req_done_q;
    logic                 timeout_q;
    logic [IDX_W-1:0]     timeout_idx_q;
    logic                 busy_q;
    logic                 tx_start_q;

    logic                 sel_vld_d;
    logic [IDX_W-1:0]     sel_idx_d;
    logic [DATA_BITS-1:0] sel_data_d;

    always_comb begin
        sel_vld_d  = 1'b0;
        sel_idx_d  = '0;
        sel_data_d = '0;
        // Scan from the furthest candidate back to the nearest so the nearest asserted one wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && (((int'(last_grant_q) + k) % NUM_REQ) == i)) begin
                    sel_vld_d  = 1'b1;
                    sel_idx_d  = IDX_W'(i);
                    sel_data_d = bus.req_data[i*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            wd_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            tx_data_q     <= '0;
            req_ack_q     <= '0;
            req_done_q    <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
            busy_q        <= 1'b0;
            tx_start_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_vld_d) begin
                        idx_q      <= sel_idx_d;
                        tx_data_q  <= sel_data_d;
                        req_ack_q  <= ONE << sel_idx_d;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    tx_start_q <= 1'b0;
                    req_ack_q  <= '0;
                    wd_cnt_q   <= '0;
                    state_q    <= S_BUSY;
                end
                S_BUSY: begin
                    wd_cnt_q <= wd_cnt_q + 24'd1;
                    // A done tick coinciding with the watchdog limit still counts as success.
                    if (bus.tx_done_tick) begin
                        req_done_q   <= ONE << idx_q;
                        last_grant_q <= idx_q;
                        gap_cnt_q    <= '0;
                        state_q      <= S_GAP;
                    end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
                        timeout_q     <= 1'b1;
                        timeout_idx_q <= idx_q;
                        last_grant_q  <= idx_q;
                        gap_cnt_q     <= '0;
                        state_q       <= S_GAP;
                    end
                end
                S_GAP: begin
                    req_done_q <= '0;
                    timeout_q  <= 1'b0;
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack     = req_ack_q;
    assign bus.req_done    = req_done_q;
    assign bus.timeout     = timeout_q;
    assign bus.timeout_idx = timeout_idx_q;
    assign bus.busy        = busy_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one instance with a long watchdog for normal traffic,
// one with a 50-cycle watchdog for abort behaviour.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus2 ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .GAP_CYCLES(1), .TIMEOUT_CYCLES(65535)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .GAP_CYCLES(1), .TIMEOUT_CYCLES(50)) dut_to (
        .clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    // Reference state: the last served requester and each requester's pending byte.
    int         last_g;
    logic [7:0] data_m [4];
    int         grants [$];

    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (mask[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        bus.req_data = {data_m[3], data_m[2], data_m[1], data_m[0]};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;  bus.tx_done_tick = 1'b0;
        bus2.req = '0; bus2.tx_done_tick = 1'b0;
        for (int i = 0; i < 4; i++) data_m[i] = 8'($urandom);
        drive_data();
        bus2.req_data = '0;
        tick(); tick();
        reset = 1'b0;
        last_g = 3;
        grants.delete();
    endtask

    // One complete frame from an idle arbiter: grant, dur BUSY cycles, done tick, gap, idle.
    task automatic run_frame(input logic [3:0] mask, input int dur);
        int         g;
        logic [3:0] oh;
        logic [7:0] sent;
        g = rr_pick(mask, last_g);
        oh = 4'b0001 << g;
        sent = data_m[g];
        bus.req = mask;
        tick();
        n_cmp++;
        if ({bus.req_ack, bus.tx_start, bus.busy, bus.tx_data} !== {oh, 1'b1, 1'b1, sent}) begin
            n_bad++;
            $display("FAIL grant: ack=%b start=%b busy=%b data=%h, required ack=%b start=1 busy=1 data=%h",
                     bus.req_ack, bus.tx_start, bus.busy, bus.tx_data, oh, sent);
        end
        grants.push_back(g);
        data_m[g] = 8'($urandom);
        drive_data();
        tick();
        n_cmp++;
        if ({bus.req_ack, bus.tx_start, bus.req_done, bus.busy} !== {4'b0, 1'b0, 4'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL busy_entry: ack=%b start=%b done=%b busy=%b, required 0000/0/0000/1",
                     bus.req_ack, bus.tx_start, bus.req_done, bus.busy);
        end
        for (int c = 0; c < dur; c++) begin
            tick();
            n_cmp++;
            if ({bus.req_done, bus.busy, bus.tx_data} !== {4'b0, 1'b1, sent}) begin
                n_bad++;
                $display("FAIL busy_hold: done=%b busy=%b data=%h, required 0000/1/%h",
                         bus.req_done, bus.busy, bus.tx_data, sent);
            end
        end
        bus.tx_done_tick = 1'b1;
        tick();
        bus.tx_done_tick = 1'b0;
        n_cmp++;
        if ({bus.req_done, bus.busy, bus.timeout} !== {oh, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL done: done=%b busy=%b timeout=%b, required done=%b busy=1 timeout=0",
                     bus.req_done, bus.busy, bus.timeout, oh);
        end
        last_g = g;
        tick();
        n_cmp++;
        if ({bus.req_done, bus.busy} !== {4'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_return: done=%b busy=%b, required 0000/0", bus.req_done, bus.busy);
        end
        bus.req = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.req_ack, bus.req_done, bus.timeout, bus.timeout_idx, bus.busy, bus.tx_start, bus.tx_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: ack=%b done=%b to=%b idx=%0d busy=%b start=%b data=%h, required all 0",
                     bus.req_ack, bus.req_done, bus.timeout, bus.timeout_idx, bus.busy, bus.tx_start, bus.tx_data);
        end
        n_cmp++;
        if ({bus2.req_ack, bus2.req_done, bus2.timeout, bus2.timeout_idx, bus2.busy, bus2.tx_start, bus2.tx_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_out2: busy=%b start=%b ack=%b, required all 0", bus2.busy, bus2.tx_start, bus2.req_ack);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        data_m[0] = 8'hA5;
        drive_data();
        run_frame(4'b0001, 199);
    endtask

    task automatic test_simultaneous();
        int exp_order [4] = '{1, 3, 1, 3};
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(4'b1010, $urandom_range(0, 12));
        for (int f = 0; f < 4; f++) begin
            n_cmp++;
            if (grants[f] !== exp_order[f]) begin
                n_bad++;
                $display("FAIL simul_order[%0d]: granted %0d, required %0d", f, grants[f], exp_order[f]);
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int f = 0; f < 8; f++) run_frame(4'b1111, $urandom_range(0, 6));
        for (int f = 0; f < 8; f++) begin
            n_cmp++;
            if (grants[f] !== (f % 4)) begin
                n_bad++;
                $display("FAIL fair_order[%0d]: granted %0d, required %0d", f, grants[f], f % 4);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 16; f++) run_frame(4'($urandom_range(1, 15)), $urandom_range(0, 30));
        for (int f = 1; f < 16; f++) begin
            n_cmp++;
            if (grants[f] < 0) begin
                n_bad++;
                $display("FAIL rand_grant[%0d]: model index %0d, required a valid index", f, grants[f]);
            end
        end
    endtask

    task automatic test_withdraw_stray();
        do_reset();
        bus.req = 4'b0001;
        tick();
        n_cmp++;
        if ({bus.req_ack, bus.tx_start} !== {4'b0001, 1'b1}) begin
            n_bad++;
            $display("FAIL wd_grant: ack=%b start=%b, required 0001/1", bus.req_ack, bus.tx_start);
        end
        bus.req = '0;
        bus.tx_done_tick = 1'b1;
        tick();
        bus.tx_done_tick = 1'b0;
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if ({bus.req_ack, bus.req_done, bus.busy} !== {4'b0, 4'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL stray_busy: ack=%b done=%b busy=%b, required 0000/0000/1",
                         bus.req_ack, bus.req_done, bus.busy);
            end
            tick();
        end
        bus.tx_done_tick = 1'b1;
        tick();
        bus.tx_done_tick = 1'b0;
        n_cmp++;
        if (bus.req_done !== 4'b0001) begin
            n_bad++;
            $display("FAIL wd_done: done=%b, required 0001", bus.req_done);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if ({bus.req_ack, bus.busy} !== {4'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL withdraw: ack=%b busy=%b, required 0000/0", bus.req_ack, bus.busy);
            end
        end
    endtask

    task automatic test_timeout();
        int g;
        do_reset();
        bus2.req_data = 32'($urandom);
        bus2.req = 4'b0010;
        g = rr_pick(4'b0010, 3);
        tick();
        n_cmp++;
        if ({bus2.req_ack, bus2.tx_start, bus2.tx_data} !== {4'b0010, 1'b1, bus2.req_data[15:8]}) begin
            n_bad++;
            $display("FAIL to_grant: ack=%b start=%b data=%h, required 0010/1/%h",
                     bus2.req_ack, bus2.tx_start, bus2.tx_data, bus2.req_data[15:8]);
        end
        bus2.req = '0;
        tick();
        for (int k = 1; k < 50; k++) begin
            tick();
            n_cmp++;
            if ({bus2.timeout, bus2.req_done, bus2.busy} !== {1'b0, 4'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL to_early k=%0d: timeout=%b done=%b busy=%b, required 0/0000/1",
                         k, bus2.timeout, bus2.req_done, bus2.busy);
            end
        end
        tick();
        n_cmp++;
        if ({bus2.timeout, bus2.timeout_idx, bus2.req_done, bus2.busy} !== {1'b1, 2'(g), 4'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL to_fire: timeout=%b idx=%0d done=%b busy=%b, required 1/%0d/0000/1",
                     bus2.timeout, bus2.timeout_idx, bus2.req_done, bus2.busy, g);
        end
        tick();
        n_cmp++;
        if ({bus2.timeout, bus2.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL to_idle: timeout=%b busy=%b, required 0/0", bus2.timeout, bus2.busy);
        end
        bus2.tx_done_tick = 1'b1;
        tick();
        bus2.tx_done_tick = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({bus2.req_done, bus2.timeout, bus2.busy, bus2.req_ack} !== '0) begin
                n_bad++;
                $display("FAIL late_tick: done=%b timeout=%b busy=%b ack=%b, required all 0",
                         bus2.req_done, bus2.timeout, bus2.busy, bus2.req_ack);
            end
            tick();
        end
        bus2.req = 4'b0110;
        tick();
        n_cmp++;
        if (bus2.req_ack !== (4'b0001 << rr_pick(4'b0110, g))) begin
            n_bad++;
            $display("FAIL to_next: ack=%b, required %b", bus2.req_ack, 4'b0001 << rr_pick(4'b0110, g));
        end
        bus2.req = '0;
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        run_frame(4'b1111, 3);
        bus.req = 4'b1111;
        tick();
        n_cmp++;
        if (bus.req_ack !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_pre_grant: ack=%b, required 0010", bus.req_ack);
        end
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({bus.req_ack, bus.req_done, bus.timeout, bus.timeout_idx, bus.busy, bus.tx_start, bus.tx_data} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: ack=%b done=%b to=%b busy=%b start=%b data=%h, required all 0",
                     bus.req_ack, bus.req_done, bus.timeout, bus.busy, bus.tx_start, bus.tx_data);
        end
        tick();
        n_cmp++;
        if ({bus.req_ack, bus.tx_start} !== {4'b0001, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_regrant: ack=%b start=%b, required 0001/1", bus.req_ack, bus.tx_start);
        end
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_simultaneous();
        test_fairness();
        test_random();
        test_withdraw_stray();
        test_timeout();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
